// File: rtl/portcullis_plant.sv
// Plant model of the portcullis drive: integrates gate position from MOT_UP/MOT_DW and reports limits.
// Single-cycle registered response; no backpressure, commands are sampled every clk edge.
module portcullis_plant #(
  parameter int TRAVEL    = 100,
  parameter int POS_W     = 8,
  parameter int STEP_DIV  = 4,
  parameter int REV_DEAD  = 3,
  parameter int STALL_MAX = 2,
  parameter int INIT_POS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MOT_UP,
  input  logic             MOT_DW,
  output logic             UP_LMT,
  output logic             DW_LMT,
  output logic [POS_W-1:0] POS,
  output logic             MOVING,
  output logic             FAULT,
  output logic             STALL_ERR
);

  localparam int DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DEAD_W  = (REV_DEAD > 1) ? $clog2(REV_DEAD) : 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  localparam logic [POS_W-1:0]   TOP_POS   = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0]   RST_POS   = POS_W'(INIT_POS);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(REV_DEAD - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  typedef enum logic [2:0] {
    S_stop,
    S_up,
    S_dw,
    S_brake,
    S_fault
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               from_up_q, from_up_d;
  logic               fault_q, fault_d;
  logic               stall_err_q, stall_err_d;
  logic               against;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_stop;
      pos_q       <= RST_POS;
      div_q       <= '0;
      dead_q      <= '0;
      stall_q     <= '0;
      from_up_q   <= 1'b0;
      fault_q     <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      div_q       <= div_d;
      dead_q      <= dead_d;
      stall_q     <= stall_d;
      from_up_q   <= from_up_d;
      fault_q     <= fault_d;
      stall_err_q <= stall_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    div_d       = '0;
    dead_d      = dead_q;
    from_up_d   = from_up_q;
    fault_d     = fault_q;
    stall_err_d = stall_err_q;
    stall_d     = '0;

    // Stall is judged on the cycle just ending, so a one-cycle turnaround never trips it.
    against = ((state_q == S_up) && (pos_q == TOP_POS)) ||
              ((state_q == S_dw) && (pos_q == '0));
    if (against) begin
      stall_d = (stall_q == STALL_LIM) ? stall_q : stall_q + 1'b1;
      if (stall_q == STALL_LIM) stall_err_d = 1'b1;
    end

    if ((state_q != S_fault) && MOT_UP && MOT_DW) begin
      state_d = S_fault;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        S_stop: begin
          if (MOT_UP)      state_d = S_up;
          else if (MOT_DW) state_d = S_dw;
        end
        S_up: begin
          if (MOT_DW) begin
            state_d   = S_brake;
            dead_d    = '0;
            from_up_d = 1'b1;
          end else if (!MOT_UP) begin
            state_d = S_stop;
          end else if (div_q == DIV_LAST) begin
            if (pos_q != TOP_POS) pos_d = pos_q + 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_dw: begin
          if (MOT_UP) begin
            state_d   = S_brake;
            dead_d    = '0;
            from_up_d = 1'b0;
          end else if (!MOT_DW) begin
            state_d = S_stop;
          end else if (div_q == DIV_LAST) begin
            if (pos_q != '0) pos_d = pos_q - 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_brake: begin
          if (!MOT_UP && !MOT_DW) begin
            state_d = S_stop;
          end else if (dead_q == DEAD_LAST) begin
            // Only an opposite-direction request survives the dead time.
            if (from_up_q ? MOT_DW : MOT_UP) state_d = from_up_q ? S_dw : S_up;
            else                             state_d = S_stop;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign UP_LMT    = (pos_q == TOP_POS);
  assign DW_LMT    = (pos_q == '0);
  assign POS       = pos_q;
  assign MOVING    = (state_q == S_up) || (state_q == S_dw);
  assign FAULT     = fault_q;
  assign STALL_ERR = stall_err_q;

endmodule

// File: tb/tb_portcullis_plant.sv
// Closed-loop bench: directed test-plan sequences plus random commands, scored against a behavioural model.
module tb_portcullis_plant;

  localparam int TRAVEL    = 8;
  localparam int POS_W     = 8;
  localparam int STEP_DIV  = 2;
  localparam int REV_DEAD  = 3;
  localparam int STALL_MAX = 2;
  localparam int INIT_POS  = 0;

  localparam int M_STOP  = 0;
  localparam int M_UP    = 1;
  localparam int M_DW    = 2;
  localparam int M_BRAKE = 3;
  localparam int M_FAULT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mot_up = 1'b0;
  logic             mot_dw = 1'b0;
  logic             up_lmt, dw_lmt, moving, fault, stall_err;
  logic [POS_W-1:0] pos;

  portcullis_plant #(
    .TRAVEL(TRAVEL), .POS_W(POS_W), .STEP_DIV(STEP_DIV),
    .REV_DEAD(REV_DEAD), .STALL_MAX(STALL_MAX), .INIT_POS(INIT_POS)
  ) dut (
    .clk(clk), .rst(rst), .MOT_UP(mot_up), .MOT_DW(mot_dw),
    .UP_LMT(up_lmt), .DW_LMT(dw_lmt), .POS(pos), .MOVING(moving),
    .FAULT(fault), .STALL_ERR(stall_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             up_lmt;
    logic             dw_lmt;
    logic             moving;
    logic             fault;
    logic             serr;
  } obs_t;

  obs_t exp_q[$];
  obs_t exp_o, act_o;
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Reference model: mode, elapsed time in the current motion/brake, and length of the stall run.
  int m_mode = M_STOP, m_pos = INIT_POS, m_elapsed = 0, m_brake_t = 0, m_from = M_UP, m_run = 0;
  bit m_fault = 0, m_serr = 0;

  function automatic void model_edge(bit up, bit dw, bit r);
    bit same, opp;
    if (r) begin
      m_mode = M_STOP; m_pos = INIT_POS; m_elapsed = 0; m_brake_t = 0;
      m_run = 0; m_fault = 0; m_serr = 0;
      return;
    end
    if ((m_mode == M_UP && m_pos == TRAVEL) || (m_mode == M_DW && m_pos == 0)) m_run++;
    else m_run = 0;
    if (m_run > STALL_MAX) m_serr = 1;

    if (m_mode != M_FAULT && up && dw) begin
      m_mode = M_FAULT; m_fault = 1;
    end else if (m_mode == M_STOP) begin
      if (up)      begin m_mode = M_UP; m_elapsed = 0; end
      else if (dw) begin m_mode = M_DW; m_elapsed = 0; end
    end else if (m_mode == M_UP || m_mode == M_DW) begin
      same = (m_mode == M_UP) ? up : dw;
      opp  = (m_mode == M_UP) ? dw : up;
      if (opp) begin
        m_from = m_mode; m_mode = M_BRAKE; m_brake_t = 0;
      end else if (!same) begin
        m_mode = M_STOP;
      end else begin
        m_elapsed++;
        if (m_elapsed == STEP_DIV) begin
          m_elapsed = 0;
          if (m_mode == M_UP && m_pos < TRAVEL) m_pos++;
          if (m_mode == M_DW && m_pos > 0)      m_pos--;
        end
      end
    end else if (m_mode == M_BRAKE) begin
      if (!up && !dw) begin
        m_mode = M_STOP;
      end else begin
        m_brake_t++;
        if (m_brake_t == REV_DEAD) begin
          if (m_from == M_UP && dw)      m_mode = M_DW;
          else if (m_from == M_DW && up) m_mode = M_UP;
          else                           m_mode = M_STOP;
          m_elapsed = 0;
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.pos    = POS_W'(m_pos);
    o.up_lmt = (m_pos == TRAVEL);
    o.dw_lmt = (m_pos == 0);
    o.moving = (m_mode == M_UP || m_mode == M_DW);
    o.fault  = m_fault;
    o.serr   = m_serr;
    return o;
  endfunction

  task automatic drive(bit up, bit dw, bit r, int n);
    for (int i = 0; i < n; i++) begin
      mot_up = up; mot_dw = dw; rst = r;
      @(posedge clk);
      model_edge(up, dw, r);
      exp_q.push_back(model_obs());
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      act_o = {pos, up_lmt, dw_lmt, moving, fault, stall_err};
      checks++;
      cyc++;
      if (act_o === exp_o) passed++;
      else $display("FAIL outputs cycle %0d: got pos=%0d up=%b dw=%b mov=%b flt=%b stl=%b, want pos=%0d up=%b dw=%b mov=%b flt=%b stl=%b",
                    cyc, act_o.pos, act_o.up_lmt, act_o.dw_lmt, act_o.moving, act_o.fault, act_o.serr,
                    exp_o.pos, exp_o.up_lmt, exp_o.dw_lmt, exp_o.moving, exp_o.fault, exp_o.serr);
    end
  end

  initial begin
    int r, len;
    bit u, d;
    // Full raise, stall at the top, flag persists after release.
    drive(0, 0, 1, 2);
    drive(1, 0, 0, 20); drive(0, 0, 0, 3); drive(0, 0, 1, 1);
    // Reversal at POS=4 through the dead time.
    drive(1, 0, 0, 9);  drive(0, 1, 0, 8); drive(0, 0, 1, 1);
    // Both commands at POS=5, then release and reset.
    drive(1, 0, 0, 11); drive(1, 1, 0, 2); drive(0, 0, 0, 3); drive(0, 0, 1, 1);
    // Partial step discarded on a one-cycle drop.
    drive(1, 0, 0, 4);  drive(0, 0, 0, 1); drive(1, 0, 0, 5); drive(0, 0, 1, 1);
    // Reset while moving down at POS=6.
    drive(1, 0, 0, 17); drive(0, 1, 0, 8); drive(0, 1, 1, 1); drive(0, 0, 0, 2);
    // One-cycle turnaround at the top, then run down into the bottom limit.
    drive(1, 0, 0, 17); drive(0, 0, 0, 1); drive(0, 1, 0, 20); drive(0, 0, 0, 2);
    drive(0, 0, 1, 1);

    for (int s = 0; s < 250; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        drive(0, 0, 1, 1);
      end else if (r < 6) begin
        drive(1, 1, 0, $urandom_range(1, 2));
      end else begin
        u   = 1'($urandom_range(0, 1));
        d   = u ? 1'b0 : 1'($urandom_range(0, 1));
        len = $urandom_range(1, 20);
        drive(u, d, 0, len);
      end
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
